mem_arbiter: RTL and testbench

- Arbitrates the single main-memory port between instruction-cache refills and data-cache refills and write-backs.
- Holds one outstanding transaction at a time and routes the memory response back to the granted cache.
- Uses round-robin priority so neither cache starves.
- Sits between the icache/dcache miss controllers and the memory model; all transfers are whole 128-bit cache lines.

---
 rtl/brisc_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// brisc_pkg: shared sizes and types for the memory arbiter and its round-robin picker.
package brisc_pkg;
    parameter int ADDRESS_BITS     = 32;
    parameter int CACHE_LINE_LEN   = 128;
    parameter int LINE_OFFSET_BITS = 4;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;
    typedef enum logic {GNT_IC, GNT_DC} arb_gnt_e;
    typedef logic [CACHE_LINE_LEN-1:0] line_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; the pointer names the side preferred on a tie.
module rr_arbiter2
    import brisc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_ic,
    input  logic req_dc,
    input  logic take,
    output logic gnt_dc
);
    arb_gnt_e ptr_q, ptr_d, pick;

    // After a grant the other side gets preference, so a held loser wins next time.
    always_comb begin
        pick  = (req_ic && req_dc) ? ptr_q : (req_dc ? GNT_DC : GNT_IC);
        ptr_d = take ? ((pick == GNT_DC) ? GNT_IC : GNT_DC) : ptr_q;
    end

    assign gnt_dc = (pick == GNT_DC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= GNT_DC;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between icache refills and dcache
// refills/write-backs, one outstanding line transfer at a time.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int ADDR_W   = ADDRESS_BITS,
    parameter int LINE_W   = CACHE_LINE_LEN,
    parameter int OFFSET_W = LINE_OFFSET_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_resp,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_resp,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_e        state_q, state_d;
    arb_gnt_e          gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              ic_resp_q, ic_resp_d;
    logic              dc_resp_q, dc_resp_d;
    logic              take;
    logic              pick_dc;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req_ic (ic_req),
        .req_dc (dc_req),
        .take   (take),
        .gnt_dc (pick_dc)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        ic_resp_d  = 1'b0;
        dc_resp_d  = 1'b0;
        take       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (ic_req || dc_req) begin
                    take    = 1'b1;
                    gnt_d   = pick_dc ? GNT_DC : GNT_IC;
                    addr_d  = (pick_dc ? dc_addr : ic_addr) & ALIGN_MASK;
                    we_d    = pick_dc && dc_we;
                    wdata_d = pick_dc ? dc_wdata : '0;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_d = mem_req_ready ? ARB_WAIT : ARB_ISSUE;
            ARB_WAIT: begin
                if (mem_resp_valid) begin
                    ic_resp_d  = (gnt_q == GNT_IC);
                    dc_resp_d  = (gnt_q == GNT_DC);
                    ic_rdata_d = (gnt_q == GNT_IC) ? mem_rdata : ic_rdata_q;
                    dc_rdata_d = (gnt_q == GNT_DC) ? mem_rdata : dc_rdata_q;
                    state_d    = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= GNT_IC;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            ic_resp_q  <= 1'b0;
            dc_resp_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
            ic_resp_q  <= ic_resp_d;
            dc_resp_q  <= dc_resp_d;
        end
    end

    assign mem_req_valid = (state_q == ARB_ISSUE);
    assign busy          = (state_q != ARB_IDLE);
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign ic_resp       = ic_resp_q;
    assign dc_resp       = dc_resp_q;
    assign ic_rdata      = ic_rdata_q;
    assign dc_rdata      = dc_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: requester and memory models around mem_arbiter, with directed scenarios
// followed by randomized rounds checked against a queue-level round-robin model.
module tb_mem_arbiter;
    typedef struct packed {
        logic [31:0]  a;
        logic         we;
        logic [127:0] d;
    } req_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
    logic [31:0]  ic_addr = '0, dc_addr = '0;
    logic [127:0] dc_wdata = '0, mem_rdata = '0;
    logic         mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic         ic_resp, dc_resp, mem_req_valid, mem_we, busy;
    logic [127:0] ic_rdata, dc_rdata, mem_wdata;
    logic [31:0]  mem_addr;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_resp(ic_resp), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_resp(dc_resp), .dc_rdata(dc_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    req_t ic_q[$], dc_q[$];
    logic [31:0]  acc_a[$];
    logic         acc_w[$];
    logic [127:0] acc_d[$];
    int           r_who[$], r_cyc[$], g_cyc[$];
    logic [127:0] r_dat[$], gave[$];
    int cyc = 0, phase = 0, wcnt = 0, pcnt = 0, cur_rdy = 0, cur_resp = 1;
    int rdy_lo = 0, rdy_hi = 0, resp_lo = 1, resp_hi = 1, unstable = 0, both_hi = 0;
    bit inject_resp = 0, fixed_en = 0;
    logic [127:0] fixed_rd = '0;
    logic [31:0]  cap_a;
    logic         cap_w;
    logic [127:0] cap_d;
    int last_dc = 0;

    // Requesters and memory: one process owns every DUT input except reset.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (ic_resp) begin
            r_who.push_back(0); r_dat.push_back(ic_rdata); r_cyc.push_back(cyc);
            if (ic_q.size() != 0) void'(ic_q.pop_front());
        end
        if (dc_resp) begin
            r_who.push_back(1); r_dat.push_back(dc_rdata); r_cyc.push_back(cyc);
            if (dc_q.size() != 0) void'(dc_q.pop_front());
        end
        if (ic_resp && dc_resp) both_hi++;
        mem_resp_valid = 1'b0;
        if (reset) begin
            ic_q.delete(); dc_q.delete();
            phase = 0; wcnt = 0; mem_req_ready = 1'b0;
        end else if (inject_resp) begin
            mem_resp_valid = 1'b1;
            mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            inject_resp = 0;
        end else if (phase == 0) begin
            mem_req_ready = 1'b0;
            if (mem_req_valid || wcnt > 0) begin
                if (wcnt == 0) begin
                    cap_a = mem_addr; cap_w = mem_we; cap_d = mem_wdata;
                    cur_rdy = $urandom_range(rdy_hi, rdy_lo);
                end else if (!mem_req_valid || mem_addr !== cap_a || mem_we !== cap_w || mem_wdata !== cap_d)
                    unstable++;
                if (wcnt >= cur_rdy) begin
                    mem_req_ready = 1'b1;
                    acc_a.push_back(cap_a); acc_w.push_back(cap_w); acc_d.push_back(cap_d);
                    phase = 1; pcnt = 0;
                    cur_resp = $urandom_range(resp_hi, resp_lo);
                end
                wcnt++;
            end
        end else begin
            mem_req_ready = 1'b0;
            if (mem_req_valid) unstable++;
            pcnt++;
            if (pcnt >= cur_resp) begin
                mem_resp_valid = 1'b1;
                mem_rdata = fixed_en ? fixed_rd : {$urandom(), $urandom(), $urandom(), $urandom()};
                gave.push_back(mem_rdata); g_cyc.push_back(cyc);
                phase = 0; wcnt = 0;
            end
        end
        ic_req = (ic_q.size() != 0);
        if (ic_req) ic_addr = ic_q[0].a;
        dc_req = (dc_q.size() != 0);
        if (dc_req) begin
            dc_addr = dc_q[0].a; dc_we = dc_q[0].we; dc_wdata = dc_q[0].d;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_resps(input int target, output bit ok);
        int t = 0;
        while (r_who.size() < target && t < 300) begin
            step();
            t++;
        end
        ok = (r_who.size() >= target);
        repeat (2) step();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({mem_req_valid, ic_resp, dc_resp, busy, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req_valid, ic_resp, dc_resp, busy, mem_we});
        end
        checks++;
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        checks++;
        if ({mem_wdata, ic_rdata, dc_rdata} !== '0) begin errors++; $display("FAIL reset_data: nonzero line output"); end
        @(posedge clk);
        #3 reset = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        int n0 = r_who.size();
        int a0 = acc_a.size();
        bit ok;
        rdy_lo = 0; rdy_hi = 1; resp_lo = 1; resp_hi = 3; fixed_en = 0;
        ic_q.push_back('{a: 32'h0000_3008, we: 1'b0, d: '0});
        dc_q.push_back('{a: 32'h0000_4004, we: 1'b0, d: '0});
        wait_resps(n0 + 2, ok);
        dc_q.push_back('{a: 32'h0000_5000, we: 1'b0, d: '0});
        wait_resps(n0 + 3, ok);
        ic_q.push_back('{a: 32'h0000_6100, we: 1'b0, d: '0});
        dc_q.push_back('{a: 32'h0000_6200, we: 1'b1, d: 128'h5});
        wait_resps(n0 + 5, ok);
        checks++;
        if (!ok || r_who.size() != n0 + 5) begin
            errors++; $display("FAIL sim_count: got %0d resps want 5", r_who.size() - n0);
        end else begin
            checks++;
            if ({r_who[n0], r_who[n0+1], r_who[n0+2], r_who[n0+3], r_who[n0+4]} !== {32'd1, 32'd0, 32'd1, 32'd0, 32'd1}) begin
                errors++; $display("FAIL sim_order: got %0d%0d%0d%0d%0d want 10101",
                                   r_who[n0], r_who[n0+1], r_who[n0+2], r_who[n0+3], r_who[n0+4]);
            end
            checks++;
            if (acc_a[a0] !== 32'h0000_4000 || acc_a[a0+1] !== 32'h0000_3000) begin
                errors++; $display("FAIL sim_addr: got %h %h want 00004000 00003000", acc_a[a0], acc_a[a0+1]);
            end
        end
        last_dc = 1;
    endtask

    task automatic test_ic_read();
        int n0 = r_who.size();
        int a0 = acc_a.size();
        int g0 = gave.size();
        bit ok;
        rdy_lo = 0; rdy_hi = 0; resp_lo = 3; resp_hi = 3;
        fixed_en = 1; fixed_rd = 128'hDEADBEEF_00112233_44556677_8899AABB;
        ic_q.push_back('{a: 32'h0000_100C, we: 1'b0, d: '0});
        wait_resps(n0 + 1, ok);
        checks++;
        if (!ok || r_who.size() != n0 + 1) begin
            errors++; $display("FAIL ic_count: got %0d resps want 1", r_who.size() - n0);
        end else begin
            checks++;
            if (acc_a[a0] !== 32'h0000_1000 || acc_w[a0] !== 1'b0) begin
                errors++; $display("FAIL ic_req: got addr %h we %b want 00001000 0", acc_a[a0], acc_w[a0]);
            end
            checks++;
            if (r_who[n0] != 0 || r_dat[n0] !== fixed_rd) begin
                errors++; $display("FAIL ic_resp: got who %0d data %h want 0 %h", r_who[n0], r_dat[n0], fixed_rd);
            end
            checks++;
            if (r_cyc[n0] != g_cyc[g0] + 1) begin
                errors++; $display("FAIL ic_latency: got %0d want %0d", r_cyc[n0] - g_cyc[g0], 1);
            end
        end
        fixed_en = 0;
        last_dc = 0;
    endtask

    task automatic test_dc_write();
        int n0 = r_who.size();
        int a0 = acc_a.size();
        bit ok;
        logic [127:0] wd = 128'h0123456789ABCDEF_0123456789ABCDEF;
        rdy_lo = 0; rdy_hi = 0; resp_lo = 2; resp_hi = 2;
        dc_q.push_back('{a: 32'h0000_2004, we: 1'b1, d: wd});
        wait_resps(n0 + 1, ok);
        checks++;
        if (!ok || r_who.size() != n0 + 1 || r_who[n0] != 1) begin
            errors++; $display("FAIL dc_resp: got %0d resps want one dc", r_who.size() - n0);
        end else begin
            checks++;
            if (acc_a[a0] !== 32'h0000_2000 || acc_w[a0] !== 1'b1 || acc_d[a0] !== wd) begin
                errors++; $display("FAIL dc_req: got addr %h we %b data %h want 00002000 1 %h", acc_a[a0], acc_w[a0], acc_d[a0], wd);
            end
        end
        last_dc = 1;
    endtask

    task automatic test_backpressure();
        int n0 = r_who.size();
        int g0 = gave.size();
        int u0 = unstable;
        int t = 0;
        bit ok;
        rdy_lo = 5; rdy_hi = 5; resp_lo = 2; resp_hi = 2;
        ic_q.push_back('{a: 32'h0000_601F, we: 1'b0, d: '0});
        while (phase != 1 && t < 50) begin step(); t++; end
        checks++;
        if (r_who.size() != n0) begin errors++; $display("FAIL bp_early: got %0d resps before response want 0", r_who.size() - n0); end
        wait_resps(n0 + 1, ok);
        checks++;
        if (unstable != u0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable - u0); end
        checks++;
        if (!ok || r_who.size() != n0 + 1 || r_cyc[n0] != g_cyc[g0] + 1) begin
            errors++; $display("FAIL bp_resp: got %0d resps want 1 one cycle after response", r_who.size() - n0);
        end
        rdy_lo = 0; rdy_hi = 0;
        last_dc = 0;
    endtask

    task automatic test_stray();
        int n0 = r_who.size();
        inject_resp = 1;
        repeat (4) step();
        checks++;
        if (r_who.size() != n0 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL stray: got resps %0d busy %b want 0 0", r_who.size() - n0, busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n0 = r_who.size();
        int t = 0;
        resp_lo = 8; resp_hi = 8; rdy_lo = 0; rdy_hi = 0;
        ic_q.push_back('{a: 32'h0000_7000, we: 1'b0, d: '0});
        while (phase != 1 && t < 50) begin step(); t++; end
        step();
        checks++;
        if (busy !== 1'b1 || mem_addr !== 32'h0000_7000) begin
            errors++; $display("FAIL rst_pre: got busy %b addr %h want 1 00007000", busy, mem_addr);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, ic_resp, dc_resp, busy, mem_we} !== 5'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_async: got ctrl %b addr %h want 0", {mem_req_valid, ic_resp, dc_resp, busy, mem_we}, mem_addr);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        inject_resp = 1;
        repeat (5) step();
        checks++;
        if (r_who.size() != n0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_late: got resps %0d busy %b want 0 0", r_who.size() - n0, busy);
        end
        last_dc = 0;
    endtask

    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            req_t ri[$], rd[$], e_req[$];
            int e_who[$];
            int nic = $urandom_range(2, 0);
            int ndc = $urandom_range(2, 0);
            int n0 = r_who.size();
            int a0 = acc_a.size();
            int g0 = gave.size();
            int u0 = unstable;
            bit ok;
            if (nic + ndc == 0) nic = 1;
            rdy_lo = 0; rdy_hi = 3; resp_lo = 1; resp_hi = 4;
            for (int i = 0; i < nic; i++) ri.push_back('{a: $urandom(), we: 1'b0, d: '0});
            for (int i = 0; i < ndc; i++)
                rd.push_back('{a: $urandom(), we: 1'($urandom_range(1, 0)),
                               d: {$urandom(), $urandom(), $urandom(), $urandom()}});
            foreach (ri[i]) ic_q.push_back(ri[i]);
            foreach (rd[i]) dc_q.push_back(rd[i]);
            // Whoever is pending wins alone; on a tie the side not served last wins.
            while (ri.size() != 0 || rd.size() != 0) begin
                int w = (ri.size() != 0 && rd.size() != 0) ? 1 - last_dc : (rd.size() != 0 ? 1 : 0);
                e_who.push_back(w);
                e_req.push_back(w == 1 ? rd.pop_front() : ri.pop_front());
                last_dc = w;
            end
            wait_resps(n0 + nic + ndc, ok);
            checks++;
            if (!ok || r_who.size() != n0 + nic + ndc || acc_a.size() != a0 + nic + ndc) begin
                errors++; $display("FAIL rnd_count: round %0d got %0d resps want %0d", r, r_who.size() - n0, nic + ndc);
                continue;
            end
            checks++;
            if (unstable != u0) begin errors++; $display("FAIL rnd_stable: round %0d got %0d unstable", r, unstable - u0); end
            foreach (e_who[k]) begin
                logic [31:0] ea = e_req[k].a & 32'hFFFF_FFF0;
                checks++;
                if (r_who[n0+k] != e_who[k]) begin
                    errors++; $display("FAIL rnd_who: round %0d txn %0d got %0d want %0d", r, k, r_who[n0+k], e_who[k]);
                end
                checks++;
                if (acc_a[a0+k] !== ea || acc_w[a0+k] !== e_req[k].we || (e_who[k] == 1 && acc_d[a0+k] !== e_req[k].d)) begin
                    errors++; $display("FAIL rnd_req: round %0d txn %0d got %h/%b want %h/%b", r, k, acc_a[a0+k], acc_w[a0+k], ea, e_req[k].we);
                end
                checks++;
                if (r_dat[n0+k] !== gave[g0+k] || r_cyc[n0+k] != g_cyc[g0+k] + 1) begin
                    errors++; $display("FAIL rnd_data: round %0d txn %0d got %h want %h", r, k, r_dat[n0+k], gave[g0+k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_ic_read();
        test_dc_write();
        test_backpressure();
        test_stray();
        test_reset_mid_wait();
        test_random(40);
        checks++;
        if (both_hi != 0) begin errors++; $display("FAIL resp_overlap: got %0d cycles want 0", both_hi); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
